// File: rtl/alu_pkg.sv
// Shared width and opcode encodings for the 40-bit registered ALU.
package alu_pkg;

   localparam int WIDTH = 40;

   localparam logic [4:0] OP_ZERO  = 5'b00000;
   localparam logic [4:0] OP_PASSA = 5'b00001;
   localparam logic [4:0] OP_PASSB = 5'b00010;
   localparam logic [4:0] OP_INC   = 5'b00011;
   localparam logic [4:0] OP_DEC   = 5'b00100;
   localparam logic [4:0] OP_ADD   = 5'b00101;
   localparam logic [4:0] OP_SUB   = 5'b00110;
   localparam logic [4:0] OP_MUL   = 5'b00111;
   localparam logic [4:0] OP_AND   = 5'b01000;
   localparam logic [4:0] OP_OR    = 5'b01001;
   localparam logic [4:0] OP_XOR   = 5'b01010;
   localparam logic [4:0] OP_NAND  = 5'b01011;
   localparam logic [4:0] OP_NOR   = 5'b01100;
   localparam logic [4:0] OP_XNOR  = 5'b01101;
   localparam logic [4:0] OP_NOT   = 5'b01110;
   localparam logic [4:0] OP_NEG   = 5'b01111;
   localparam logic [4:0] OP_SHL   = 5'b10000;
   localparam logic [4:0] OP_SHR   = 5'b10001;
   localparam logic [4:0] OP_SRA   = 5'b10010;
   localparam logic [4:0] OP_ROL   = 5'b10011;
   localparam logic [4:0] OP_ROR   = 5'b10100;
   localparam logic [4:0] OP_EQ    = 5'b10101;
   localparam logic [4:0] OP_LTU   = 5'b10110;
   localparam logic [4:0] OP_LTS   = 5'b10111;
   localparam logic [4:0] OP_MAXU  = 5'b11000;
   localparam logic [4:0] OP_MINU  = 5'b11001;

endpackage

// File: rtl/alu_shifter.sv
// Combinational shift/rotate unit: SHL/SHR/SRA on b[5:0], ROL/ROR on b mod WIDTH.
module alu_shifter
   import alu_pkg::*;
(
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [4:0]       op,
   output logic [WIDTH-1:0] y
);

   localparam logic [WIDTH-1:0] WIDTH_V = WIDTH;

   logic [5:0]       amt;
   logic [WIDTH-1:0] rem;

   assign amt = b[5:0];
   assign rem = b % WIDTH_V;

   // rem==0 leaves the complementary term shifted by a full WIDTH, i.e. zero
   always_comb begin
      y = '0;
      case (op)
         OP_SHL: y = a << amt;
         OP_SHR: y = a >> amt;
         OP_SRA: y = $signed(a) >>> amt;
         OP_ROL: y = (a << rem) | (a >> (WIDTH_V - rem));
         OP_ROR: y = (a >> rem) | (a << (WIDTH_V - rem));
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/alu.sv
// 40-bit ALU: combinational opcode decode into next_out, registered every clock.
module alu
   import alu_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [4:0]       s,
   output logic [WIDTH-1:0] out
);

   logic [WIDTH-1:0] next_out;
   logic [WIDTH-1:0] shift_y;

   alu_shifter u_shifter (
      .a  (a),
      .b  (b),
      .op (s),
      .y  (shift_y)
   );

   always_comb begin
      next_out = '0;
      case (s)
         OP_ZERO:  next_out = '0;
         OP_PASSA: next_out = a;
         OP_PASSB: next_out = b;
         OP_INC:   next_out = a + 1'b1;
         OP_DEC:   next_out = a - 1'b1;
         OP_ADD:   next_out = a + b;
         OP_SUB:   next_out = a - b;
         OP_MUL:   next_out = a * b;
         OP_AND:   next_out = a & b;
         OP_OR:    next_out = a | b;
         OP_XOR:   next_out = a ^ b;
         OP_NAND:  next_out = ~(a & b);
         OP_NOR:   next_out = ~(a | b);
         OP_XNOR:  next_out = ~(a ^ b);
         OP_NOT:   next_out = ~a;
         OP_NEG:   next_out = '0 - a;
         OP_SHL, OP_SHR, OP_SRA, OP_ROL, OP_ROR:
                   next_out = shift_y;
         OP_EQ:    next_out = {{(WIDTH-1){1'b0}}, a == b};
         OP_LTU:   next_out = {{(WIDTH-1){1'b0}}, a < b};
         OP_LTS:   next_out = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         OP_MAXU:  next_out = (a > b) ? a : b;
         OP_MINU:  next_out = (a < b) ? a : b;
         default:  next_out = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) out <= '0;
      else        out <= next_out;
   end

endmodule

// File: tb/tb_alu.sv
// Directed and random checks of the registered ALU against an arithmetic reference model.
module tb_alu;

   logic        clk;
   logic        rst_n;
   logic [39:0] a;
   logic [39:0] b;
   logic [4:0]  s;
   logic [39:0] out;

   int total = 0;
   int bad   = 0;

   alu dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .b     (b),
      .s     (s),
      .out   (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [39:0] model(input logic [39:0] x, input logic [39:0] y,
                                         input logic [4:0] op);
      longint unsigned ux = x;
      longint unsigned uy = y;
      longint unsigned r  = 0;
      longint          sx;
      longint          sy;
      longint unsigned p40 = 64'd1 << 40;
      int unsigned     amt = y[5:0];
      int unsigned     n;
      logic [39:0]     v;
      sx = (ux >= (p40 >> 1)) ? longint'(ux) - longint'(p40) : longint'(ux);
      sy = (uy >= (p40 >> 1)) ? longint'(uy) - longint'(p40) : longint'(uy);
      case (op)
         5'd0:  r = 0;
         5'd1:  r = ux;
         5'd2:  r = uy;
         5'd3:  r = ux + 1;
         5'd4:  r = ux + p40 - 1;
         5'd5:  r = ux + uy;
         5'd6:  r = ux + p40 - uy;
         5'd7:  r = ux * uy;
         5'd8:  r = ux & uy;
         5'd9:  r = ux | uy;
         5'd10: r = ux ^ uy;
         5'd11: r = ~(ux & uy);
         5'd12: r = ~(ux | uy);
         5'd13: r = ~(ux ^ uy);
         5'd14: r = ~ux;
         5'd15: r = p40 - ux;
         5'd16: r = (amt >= 40) ? 0 : (ux << amt);
         5'd17: r = (amt >= 40) ? 0 : (ux >> amt);
         5'd18: begin
            n = (amt >= 40) ? 40 : amt;
            v = x;
            for (int unsigned i = 0; i < n; i++) v = {v[39], v[39:1]};
            r = v;
         end
         5'd19: begin
            n = int'(uy % 40);
            v = x;
            for (int unsigned i = 0; i < n; i++) v = {v[38:0], v[39]};
            r = v;
         end
         5'd20: begin
            n = int'(uy % 40);
            v = x;
            for (int unsigned i = 0; i < n; i++) v = {v[0], v[39:1]};
            r = v;
         end
         5'd21: r = (ux == uy) ? 1 : 0;
         5'd22: r = (ux < uy) ? 1 : 0;
         5'd23: r = (sx < sy) ? 1 : 0;
         5'd24: r = (ux > uy) ? ux : uy;
         5'd25: r = (ux < uy) ? ux : uy;
         default: r = 0;
      endcase
      return r[39:0];
   endfunction

   task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // drive on the falling edge, sample 1 time unit after the capturing edge
   task automatic step(input logic [39:0] na, input logic [39:0] nb, input logic [4:0] ns,
                       input logic [39:0] exp, input string tag);
      @(negedge clk);
      a = na;
      b = nb;
      s = ns;
      @(posedge clk);
      #1;
      check(tag, out, exp);
      check({tag, "_model"}, out, model(na, nb, ns));
   endtask

   initial begin
      logic [63:0] ra;
      logic [63:0] rb;
      logic [4:0]  rs;

      rst_n = 1'b1;
      a = 40'h12345;
      b = 40'h777;
      s = 5'b00101;
      #2 rst_n = 1'b0;
      #1 check("reset_async", out, 40'h0);
      @(posedge clk);
      #1 check("reset_hold", out, 40'h0);

      @(negedge clk);
      rst_n = 1'b1;
      step(40'h0B, 40'h03, 5'b00101, 40'h000000000E, "first_add");
      step(40'h0B, 40'h03, 5'b00111, 40'h21, "mul");
      step(40'h0B, 40'h03, 5'b00110, 40'h08, "sub");
      step(40'h0B, 40'h03, 5'b01000, 40'h03, "and");
      step(40'h0B, 40'h03, 5'b01011, 40'hFFFFFFFFFC, "nand");
      step(40'h0B, 40'h03, 5'b01100, 40'hFFFFFFFFF4, "nor");
      step(40'h0B, 40'h03, 5'b10100, 40'h6000000001, "ror3");
      step(40'hFFFFFFFFFF, 40'h1, 5'b00101, 40'h0, "add_wrap");
      step(40'h0, 40'h1, 5'b00110, 40'hFFFFFFFFFF, "sub_wrap");
      step(40'h8000000000, 40'd45, 5'b10010, 40'hFFFFFFFFFF, "sra45");
      step(40'h8000000000, 40'd45, 5'b10001, 40'h0, "shr45");
      step(40'h8000000000, 40'd41, 5'b10011, 40'h0000000001, "rol41");
      step(40'h8000000000, 40'd40, 5'b10000, 40'h0, "shl40");
      step(40'h8000000000, 40'd39, 5'b10010, 40'hFFFFFFFFFF, "sra39");
      step(40'h123456789A, 40'd80, 5'b10011, 40'h123456789A, "rol80");
      step(40'h8000000000, 40'h1, 5'b10110, 40'h0, "ltu");
      step(40'h8000000000, 40'h1, 5'b10111, 40'h1, "lts");
      step(40'h8000000000, 40'h1, 5'b11111, 40'h0, "reserved");

      // only the opcode present at the edge is captured
      @(negedge clk);
      a = 40'h8000000000;
      b = 40'h1;
      s = 5'b01010;
      #3 s = 5'b10111;
      @(posedge clk);
      #1 check("s_at_edge", out, 40'h1);
      #1 s = 5'b11111;
      #1 check("out_holds", out, 40'h1);
      @(posedge clk);
      #1 check("s_changed", out, 40'h0);

      // reset mid-stream overrides the pending capture
      @(negedge clk);
      a = 40'h5;
      b = 40'h6;
      s = 5'b00101;
      #2 rst_n = 1'b0;
      #1 check("reset_mid", out, 40'h0);
      @(posedge clk);
      #1 check("reset_mid_hold", out, 40'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step(40'h5, 40'h6, 5'b00101, 40'hB, "after_reset");

      for (int i = 0; i < 400; i++) begin
         ra = {$urandom(), $urandom()};
         rb = {$urandom(), $urandom()};
         if ($urandom_range(0, 2) == 0) rb = 64'($urandom_range(0, 90));
         rs = 5'($urandom_range(0, 31));
         @(negedge clk);
         a = ra[39:0];
         b = rb[39:0];
         s = rs;
         @(posedge clk);
         #1;
         check($sformatf("rand_s%0d", rs), out, model(ra[39:0], rb[39:0], rs));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
